mii_frame_checker: RTL and testbench

MII_FRAME_CHECKER -- requirements
Module: mii_frame_checker

---
 rtl/mii_frame_checker_if.sv | 23 ++
 rtl/mii_frame_checker.sv | 203 ++++++++++++++++++++
 tb/tb_mii_frame_checker.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mii_frame_checker_if.sv
// mii_frame_checker_if
//   Receive-side bus carrying one MII word per clock into the frame checker.
//   Build-time option: none (the frame checker itself honours MII_FRAME_STATS_EN).
//
//   Signals
//     i_rx_data  DATA_WIDTH  received word, byte 0 in bits [7:0]
//     i_rx_ctrl  1           1 = control word, 0 = data word
//
//   Modports
//     master  : drives the word (PHY side / testbench)
//     slave   : consumes the word (frame checker)
interface mii_frame_checker_if #(
  parameter int DATA_WIDTH = 64
) ();

  logic [DATA_WIDTH-1:0] i_rx_data;
  logic                  i_rx_ctrl;

  // The bus is purely unidirectional; the checker never back-pressures.
  modport master (output i_rx_data, output i_rx_ctrl);
  modport slave  (input  i_rx_data, input  i_rx_ctrl);

endinterface

// File: rtl/mii_frame_checker.sv
// mii_frame_checker
//   Watches a stream of MII words (one per clock, no back-pressure) and checks
//   that each frame is START, exactly DATA_LENGTH data words of DATA_CHAR, EOF.
//   Good frames give a one-cycle o_frame_ok pulse; protocol or content problems
//   give a one-cycle o_frame_err pulse with a cause held on o_err_code.
//
//   Build-time option: MII_FRAME_STATS_EN
//     defined   -> o_good_frames / o_bad_frames are saturating frame counters
//     undefined -> counters removed, both outputs tied to 0
//
//   Ports
//     clk           rising-edge clock
//     i_rst_n       asynchronous active-low reset
//     rx            mii_frame_checker_if.slave (i_rx_data, i_rx_ctrl)
//     o_in_frame    high while inside a frame (DATA state)
//     o_frame_ok    one-cycle pulse, frame ended correctly
//     o_frame_err   one-cycle pulse, error detected
//     o_err_code    cause of the latest error (held)
//     o_word_count  data words in the current or last frame
//     o_good_frames good frame count
//     o_bad_frames  bad frame count (length, pattern, truncated, restart)
module mii_frame_checker #(
  parameter int         DATA_WIDTH  = 64,
  parameter int         DATA_LENGTH = 64,
  parameter int         CNT_WIDTH   = 16,
  parameter logic [7:0] IDLE_CODE   = 8'h07,
  parameter logic [7:0] START_CODE  = 8'hFB,
  parameter logic [7:0] EOF_CODE    = 8'hFD,
  parameter logic [7:0] DATA_CHAR   = 8'hAA
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  mii_frame_checker_if.slave   rx,
  output logic                 o_in_frame,
  output logic                 o_frame_ok,
  output logic                 o_frame_err,
  output logic [2:0]           o_err_code,
  output logic [CNT_WIDTH-1:0] o_word_count,
  output logic [CNT_WIDTH-1:0] o_good_frames,
  output logic [CNT_WIDTH-1:0] o_bad_frames
);

  localparam int NBYTES = DATA_WIDTH / 8;

  localparam logic [2:0] ERR_LENGTH    = 3'd1;
  localparam logic [2:0] ERR_PATTERN   = 3'd2;
  localparam logic [2:0] ERR_OUTSIDE   = 3'd3;
  localparam logic [2:0] ERR_TRUNCATED = 3'd4;
  localparam logic [2:0] ERR_RESTART   = 3'd5;
  localparam logic [2:0] ERR_UNKNOWN   = 3'd6;

  typedef enum logic {
    S_IDLE,
    S_DATA
  } state_t;

  state_t               state_q;
  logic [CNT_WIDTH-1:0] wordCount_q;
  logic                 patternBad_q;
  logic                 frameOk_q;
  logic                 frameErr_q;
  logic [2:0]           errCode_q;

  logic                 allIdleBytes;
  logic                 allDataBytes;
  logic                 isIdleWord;
  logic                 isStartWord;
  logic                 isEofWord;
  logic                 okEvent;
  logic                 errEvent;
  logic [2:0]           errCode_d;

  // Byte-wise scan of the incoming word: an IDLE control word needs every
  // byte to be IDLE_CODE, and a data word is clean only if every byte is
  // DATA_CHAR.
  always_comb begin
    allIdleBytes = 1'b1;
    allDataBytes = 1'b1;
    for (int b = 0; b < NBYTES; b++) begin
      if (rx.i_rx_data[8*b +: 8] != IDLE_CODE) allIdleBytes = 1'b0;
      if (rx.i_rx_data[8*b +: 8] != DATA_CHAR) allDataBytes = 1'b0;
    end
  end

  // START and EOF are recognised on byte 0 alone; upper bytes are don't-care.
  assign isIdleWord  = rx.i_rx_ctrl && allIdleBytes;
  assign isStartWord = rx.i_rx_ctrl && (rx.i_rx_data[7:0] == START_CODE);
  assign isEofWord   = rx.i_rx_ctrl && (rx.i_rx_data[7:0] == EOF_CODE);

  // Decide, for the word on the bus this cycle, whether it completes a good
  // frame or raises exactly one error, and which cause that error carries.
  always_comb begin
    okEvent   = 1'b0;
    errEvent  = 1'b0;
    errCode_d = 3'd0;
    case (state_q)
      S_IDLE: begin
        if (!rx.i_rx_ctrl) begin
          errEvent  = 1'b1;
          errCode_d = ERR_OUTSIDE;
        end else if (!isIdleWord && !isStartWord) begin
          errEvent  = 1'b1;
          errCode_d = ERR_UNKNOWN;
        end
      end
      S_DATA: begin
        if (rx.i_rx_ctrl) begin
          if (isEofWord) begin
            if (patternBad_q) begin
              errEvent  = 1'b1;
              errCode_d = ERR_PATTERN;
            end else if (wordCount_q != CNT_WIDTH'(DATA_LENGTH)) begin
              errEvent  = 1'b1;
              errCode_d = ERR_LENGTH;
            end else begin
              okEvent = 1'b1;
            end
          end else if (isStartWord) begin
            errEvent  = 1'b1;
            errCode_d = ERR_RESTART;
          end else begin
            errEvent  = 1'b1;
            errCode_d = ERR_TRUNCATED;
          end
        end
      end
      default: ;
    endcase
  end

  // Frame FSM plus the registered status pulses. A START always opens a fresh
  // frame (clearing count and pattern flag), even when it interrupts one.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      wordCount_q  <= '0;
      patternBad_q <= 1'b0;
      frameOk_q    <= 1'b0;
      frameErr_q   <= 1'b0;
      errCode_q    <= 3'd0;
    end else begin
      frameOk_q  <= okEvent;
      frameErr_q <= errEvent;
      if (errEvent) errCode_q <= errCode_d;
      case (state_q)
        S_IDLE: begin
          if (isStartWord) begin
            state_q      <= S_DATA;
            wordCount_q  <= '0;
            patternBad_q <= 1'b0;
          end
        end
        S_DATA: begin
          if (!rx.i_rx_ctrl) begin
            if (wordCount_q != '1) wordCount_q <= wordCount_q + 1'b1;
            if (!allDataBytes) patternBad_q <= 1'b1;
          end else if (isStartWord) begin
            wordCount_q  <= '0;
            patternBad_q <= 1'b0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_in_frame   = (state_q == S_DATA);
  assign o_frame_ok   = frameOk_q;
  assign o_frame_err  = frameErr_q;
  assign o_err_code   = errCode_q;
  assign o_word_count = wordCount_q;

`ifdef MII_FRAME_STATS_EN
  logic [CNT_WIDTH-1:0] goodFrames_q;
  logic [CNT_WIDTH-1:0] badFrames_q;
  logic                 badEvent;

  // Only frame-level failures count as bad frames; stray data outside a frame
  // and unknown control words do not.
  assign badEvent = errEvent && ((errCode_d == ERR_LENGTH) || (errCode_d == ERR_PATTERN) ||
                                 (errCode_d == ERR_TRUNCATED) || (errCode_d == ERR_RESTART));

  // Saturating statistics, updated alongside the pulses they count.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      goodFrames_q <= '0;
      badFrames_q  <= '0;
    end else begin
      if (okEvent && (goodFrames_q != '1)) goodFrames_q <= goodFrames_q + 1'b1;
      if (badEvent && (badFrames_q != '1)) badFrames_q <= badFrames_q + 1'b1;
    end
  end

  assign o_good_frames = goodFrames_q;
  assign o_bad_frames  = badFrames_q;
`else
  assign o_good_frames = '0;
  assign o_bad_frames  = '0;
`endif

endmodule

// File: tb/tb_mii_frame_checker.sv
// tb_mii_frame_checker
//   Directed bench for mii_frame_checker. Words are driven on the falling edge
//   so each rising edge samples exactly one word; results of a word are read
//   at the following falling edge. Expected statistics follow whether
//   MII_FRAME_STATS_EN is defined for the build.
module tb_mii_frame_checker;

  localparam int DW = 64;
  localparam int CW = 16;

`ifdef MII_FRAME_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
  localparam logic [63:0] START_W = 64'h0123456789ABCDFB;
  localparam logic [63:0] EOF_W   = 64'hFFEEDDCCBBAA99FD;
  localparam logic [63:0] DATA_W  = 64'hAAAAAAAAAAAAAAAA;
  localparam logic [63:0] BAD_W   = 64'hAAAAAAAAAAAAAAAB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          inFrame;
  logic          frameOk;
  logic          frameErr;
  logic [2:0]    errCode;
  logic [CW-1:0] wordCount;
  logic [CW-1:0] goodFrames;
  logic [CW-1:0] badFrames;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  mii_frame_checker_if #(.DATA_WIDTH(DW)) rxIf ();

  mii_frame_checker #(
    .DATA_WIDTH(DW),
    .DATA_LENGTH(64),
    .CNT_WIDTH(CW)
  ) dut (
    .clk          (clk),
    .i_rst_n      (rst_n),
    .rx           (rxIf),
    .o_in_frame   (inFrame),
    .o_frame_ok   (frameOk),
    .o_frame_err  (frameErr),
    .o_err_code   (errCode),
    .o_word_count (wordCount),
    .o_good_frames(goodFrames),
    .o_bad_frames (badFrames)
  );

  // Statistics only count when the feature is built in.
  function automatic logic [CW-1:0] expStat(input int n);
    return STATS_ON ? CW'(n) : '0;
  endfunction

  // Put one word on the bus for the next rising edge.
  task automatic applyStimulus(input logic ctrl, input logic [63:0] data);
    @(negedge clk);
    rxIf.i_rx_ctrl = ctrl;
    rxIf.i_rx_data = data;
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst_n          = 1'b0;
    rxIf.i_rx_ctrl = 1'b1;
    rxIf.i_rx_data = IDLE_W;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // START, n data words (word badIdx corrupted, -1 for none), EOF.
  task automatic sendFrame(input int n, input int badIdx);
    applyStimulus(1'b1, START_W);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, (i == badIdx) ? BAD_W : DATA_W);
    applyStimulus(1'b1, EOF_W);
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    rxIf.i_rx_ctrl = 1'b1;
    rxIf.i_rx_data = IDLE_W;
    repeat (3) @(negedge clk);
    testsRun++; if (inFrame !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_in_frame: got %0b want 0", inFrame); end
    testsRun++; if (frameOk !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ok: got %0b want 0", frameOk); end
    testsRun++; if (frameErr !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_err: got %0b want 0", frameErr); end
    testsRun++; if (errCode !== 3'd0) begin testsFailed++; $display("[TB] FAIL reset_code: got %0d want 0", errCode); end
    testsRun++; if (wordCount !== '0) begin testsFailed++; $display("[TB] FAIL reset_count: got %0d want 0", wordCount); end
    testsRun++; if (goodFrames !== '0) begin testsFailed++; $display("[TB] FAIL reset_good: got %0d want 0", goodFrames); end
    testsRun++; if (badFrames !== '0) begin testsFailed++; $display("[TB] FAIL reset_bad: got %0d want 0", badFrames); end
    rst_n = 1'b1;
  endtask

  task automatic test_good_frame();
    applyReset();
    repeat (16) applyStimulus(1'b1, IDLE_W);
    applyStimulus(1'b1, START_W);
    applyStimulus(1'b0, DATA_W);
    testsRun++; if (inFrame !== 1'b1) begin testsFailed++; $display("[TB] FAIL good_in_frame: got %0b want 1", inFrame); end
    repeat (63) applyStimulus(1'b0, DATA_W);
    applyStimulus(1'b1, EOF_W);
    applyStimulus(1'b1, IDLE_W);
    testsRun++; if (frameOk !== 1'b1) begin testsFailed++; $display("[TB] FAIL good_ok: got %0b want 1", frameOk); end
    testsRun++; if (frameErr !== 1'b0) begin testsFailed++; $display("[TB] FAIL good_err: got %0b want 0", frameErr); end
    testsRun++; if (errCode !== 3'd0) begin testsFailed++; $display("[TB] FAIL good_code: got %0d want 0", errCode); end
    testsRun++; if (wordCount !== 16'd64) begin testsFailed++; $display("[TB] FAIL good_count: got %0d want 64", wordCount); end
    testsRun++; if (inFrame !== 1'b0) begin testsFailed++; $display("[TB] FAIL good_left_frame: got %0b want 0", inFrame); end
    testsRun++; if (goodFrames !== expStat(1)) begin testsFailed++; $display("[TB] FAIL good_stat_good: got %0d want %0d", goodFrames, expStat(1)); end
    testsRun++; if (badFrames !== expStat(0)) begin testsFailed++; $display("[TB] FAIL good_stat_bad: got %0d want %0d", badFrames, expStat(0)); end
    applyStimulus(1'b1, IDLE_W);
    testsRun++; if (frameOk !== 1'b0) begin testsFailed++; $display("[TB] FAIL good_ok_one_cycle: got %0b want 0", frameOk); end
  endtask

  task automatic test_length();
    applyReset();
    sendFrame(63, -1);
    applyStimulus(1'b1, IDLE_W);
    testsRun++; if (frameErr !== 1'b1) begin testsFailed++; $display("[TB] FAIL len_err: got %0b want 1", frameErr); end
    testsRun++; if (frameOk !== 1'b0) begin testsFailed++; $display("[TB] FAIL len_ok: got %0b want 0", frameOk); end
    testsRun++; if (errCode !== 3'd1) begin testsFailed++; $display("[TB] FAIL len_code: got %0d want 1", errCode); end
    testsRun++; if (wordCount !== 16'd63) begin testsFailed++; $display("[TB] FAIL len_count: got %0d want 63", wordCount); end
    testsRun++; if (badFrames !== expStat(1)) begin testsFailed++; $display("[TB] FAIL len_stat_bad: got %0d want %0d", badFrames, expStat(1)); end
    applyStimulus(1'b1, IDLE_W);
    testsRun++; if (frameErr !== 1'b0) begin testsFailed++; $display("[TB] FAIL len_err_one_cycle: got %0b want 0", frameErr); end
    testsRun++; if (errCode !== 3'd1) begin testsFailed++; $display("[TB] FAIL len_code_held: got %0d want 1", errCode); end
  endtask

  task automatic test_pattern();
    applyReset();
    sendFrame(64, 31);
    applyStimulus(1'b1, IDLE_W);
    testsRun++; if (frameErr !== 1'b1) begin testsFailed++; $display("[TB] FAIL pat_err: got %0b want 1", frameErr); end
    testsRun++; if (frameOk !== 1'b0) begin testsFailed++; $display("[TB] FAIL pat_ok: got %0b want 0", frameOk); end
    testsRun++; if (errCode !== 3'd2) begin testsFailed++; $display("[TB] FAIL pat_code: got %0d want 2", errCode); end
    testsRun++; if (badFrames !== expStat(1)) begin testsFailed++; $display("[TB] FAIL pat_stat_bad: got %0d want %0d", badFrames, expStat(1)); end
    testsRun++; if (goodFrames !== expStat(0)) begin testsFailed++; $display("[TB] FAIL pat_stat_good: got %0d want %0d", goodFrames, expStat(0)); end
  endtask

  task automatic test_outside();
    applyReset();
    applyStimulus(1'b0, 64'h0);
    applyStimulus(1'b1, IDLE_W);
    testsRun++; if (frameErr !== 1'b1) begin testsFailed++; $display("[TB] FAIL out_err: got %0b want 1", frameErr); end
    testsRun++; if (errCode !== 3'd3) begin testsFailed++; $display("[TB] FAIL out_code: got %0d want 3", errCode); end
    testsRun++; if (inFrame !== 1'b0) begin testsFailed++; $display("[TB] FAIL out_in_frame: got %0b want 0", inFrame); end
    testsRun++; if (badFrames !== expStat(0)) begin testsFailed++; $display("[TB] FAIL out_stat_bad: got %0d want %0d", badFrames, expStat(0)); end
    sendFrame(64, -1);
    applyStimulus(1'b1, IDLE_W);
    testsRun++; if (frameOk !== 1'b1) begin testsFailed++; $display("[TB] FAIL out_then_ok: got %0b want 1", frameOk); end
    testsRun++; if (errCode !== 3'd3) begin testsFailed++; $display("[TB] FAIL out_code_held: got %0d want 3", errCode); end
    testsRun++; if (goodFrames !== expStat(1)) begin testsFailed++; $display("[TB] FAIL out_stat_good: got %0d want %0d", goodFrames, expStat(1)); end
  endtask

  task automatic test_restart();
    applyReset();
    applyStimulus(1'b1, START_W);
    repeat (10) applyStimulus(1'b0, DATA_W);
    applyStimulus(1'b1, START_W);
    applyStimulus(1'b0, DATA_W);
    testsRun++; if (frameErr !== 1'b1) begin testsFailed++; $display("[TB] FAIL rst_err: got %0b want 1", frameErr); end
    testsRun++; if (errCode !== 3'd5) begin testsFailed++; $display("[TB] FAIL rst_code: got %0d want 5", errCode); end
    testsRun++; if (inFrame !== 1'b1) begin testsFailed++; $display("[TB] FAIL rst_in_frame: got %0b want 1", inFrame); end
    testsRun++; if (wordCount !== 16'd0) begin testsFailed++; $display("[TB] FAIL rst_count_clear: got %0d want 0", wordCount); end
    repeat (63) applyStimulus(1'b0, DATA_W);
    applyStimulus(1'b1, EOF_W);
    applyStimulus(1'b1, IDLE_W);
    testsRun++; if (frameOk !== 1'b1) begin testsFailed++; $display("[TB] FAIL rst_then_ok: got %0b want 1", frameOk); end
    testsRun++; if (goodFrames !== expStat(1)) begin testsFailed++; $display("[TB] FAIL rst_stat_good: got %0d want %0d", goodFrames, expStat(1)); end
    testsRun++; if (badFrames !== expStat(1)) begin testsFailed++; $display("[TB] FAIL rst_stat_bad: got %0d want %0d", badFrames, expStat(1)); end
  endtask

  task automatic test_truncated();
    applyReset();
    applyStimulus(1'b1, START_W);
    repeat (5) applyStimulus(1'b0, DATA_W);
    applyStimulus(1'b1, IDLE_W);
    applyStimulus(1'b1, IDLE_W);
    testsRun++; if (frameErr !== 1'b1) begin testsFailed++; $display("[TB] FAIL trunc_err: got %0b want 1", frameErr); end
    testsRun++; if (errCode !== 3'd4) begin testsFailed++; $display("[TB] FAIL trunc_code: got %0d want 4", errCode); end
    testsRun++; if (inFrame !== 1'b0) begin testsFailed++; $display("[TB] FAIL trunc_in_frame: got %0b want 0", inFrame); end
    testsRun++; if (wordCount !== 16'd5) begin testsFailed++; $display("[TB] FAIL trunc_count: got %0d want 5", wordCount); end
    testsRun++; if (badFrames !== expStat(1)) begin testsFailed++; $display("[TB] FAIL trunc_stat_bad: got %0d want %0d", badFrames, expStat(1)); end
  endtask

  task automatic test_unknown();
    applyReset();
    applyStimulus(1'b1, 64'h0707070707070755);
    applyStimulus(1'b1, IDLE_W);
    testsRun++; if (frameErr !== 1'b1) begin testsFailed++; $display("[TB] FAIL unk_err: got %0b want 1", frameErr); end
    testsRun++; if (errCode !== 3'd6) begin testsFailed++; $display("[TB] FAIL unk_code: got %0d want 6", errCode); end
    testsRun++; if (badFrames !== expStat(0)) begin testsFailed++; $display("[TB] FAIL unk_stat_bad: got %0d want %0d", badFrames, expStat(0)); end
  endtask

  task automatic test_midframe_reset();
    applyReset();
    applyStimulus(1'b1, START_W);
    repeat (30) applyStimulus(1'b0, DATA_W);
    @(negedge clk);
    testsRun++; if (wordCount !== 16'd30) begin testsFailed++; $display("[TB] FAIL mid_count_before: got %0d want 30", wordCount); end
    rst_n = 1'b0;
    #1;
    testsRun++; if (inFrame !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_in_frame: got %0b want 0", inFrame); end
    testsRun++; if (wordCount !== '0) begin testsFailed++; $display("[TB] FAIL mid_count: got %0d want 0", wordCount); end
    testsRun++; if ({frameOk, frameErr, errCode} !== 5'd0) begin testsFailed++; $display("[TB] FAIL mid_flags: got %0h want 0", {frameOk, frameErr, errCode}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sendFrame(64, -1);
    applyStimulus(1'b1, IDLE_W);
    testsRun++; if (frameOk !== 1'b1) begin testsFailed++; $display("[TB] FAIL mid_then_ok: got %0b want 1", frameOk); end
    testsRun++; if (goodFrames !== expStat(1)) begin testsFailed++; $display("[TB] FAIL mid_stat_good: got %0d want %0d", goodFrames, expStat(1)); end
    testsRun++; if (badFrames !== expStat(0)) begin testsFailed++; $display("[TB] FAIL mid_stat_bad: got %0d want %0d", badFrames, expStat(0)); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_length();
    test_pattern();
    test_outside();
    test_restart();
    test_truncated();
    test_unknown();
    test_midframe_reset();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
